// File: rtl/otp_i2c_sequencer_if.sv
// otp_i2c_sequencer_if: requester handshakes plus the byte-level engine command bus.
// master = sequencer side, slave = requesters/engine side.
// All signals are single-clock, sampled on the rising edge of clk.
interface otp_i2c_sequencer_if;
    // OTP command requester
    logic       otp_req;
    logic       otp_wr;
    logic       otp_gnt;
    logic       otp_busy;
    logic       otp_done;
    logic       otp_err;
    // host single-write requester
    logic       host_req;
    logic [7:0] host_reg;
    logic [7:0] host_data;
    logic       host_gnt;
    logic       host_done;
    logic       host_err;
    // engine command / completion
    logic       eng_valid;
    logic       eng_ready;
    logic [6:0] eng_dev;
    logic [7:0] eng_reg;
    logic [7:0] eng_data;
    logic       eng_done;
    logic       eng_nack;

    modport master (
        input  otp_req, otp_wr, host_req, host_reg, host_data,
               eng_ready, eng_done, eng_nack,
        output otp_gnt, otp_busy, otp_done, otp_err,
               host_gnt, host_done, host_err,
               eng_valid, eng_dev, eng_reg, eng_data
    );

    modport slave (
        output otp_req, otp_wr, host_req, host_reg, host_data,
               eng_ready, eng_done, eng_nack,
        input  otp_gnt, otp_busy, otp_done, otp_err,
               host_gnt, host_done, host_err,
               eng_valid, eng_dev, eng_reg, eng_data
    );
endinterface

// File: rtl/otp_i2c_sequencer.sv
// otp_i2c_sequencer: shares one I2C write engine between the OTP unlock+command sequence and host single writes.
// Latency: grant and first eng_valid one cycle after a request is seen in IDLE; GAP_CYCLES idle cycles between engine commands.
// Backpressure: eng_valid holds with stable fields until eng_ready; requests are level and wait while a sequence runs.
module otp_i2c_sequencer #(
    parameter logic [6:0]  DEV_ADDR   = 7'h0A,
    parameter logic [7:0]  PASS_REG   = 8'h05,
    parameter logic [7:0]  OTP_REG    = 8'h04,
    parameter logic [47:0] PASSCODE   = 48'h50_48_53_47_4E_58,
    parameter int          GAP_CYCLES = 8,
    parameter int          MAX_RETRY  = 2
) (
    input  logic                clk,
    input  logic                rst,
    otp_i2c_sequencer_if.master bus
);

    localparam logic [7:0] LP_GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [2:0] LP_MAX_RETRY = 3'(MAX_RETRY);
    localparam logic [2:0] LP_OTP_LAST  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_owner_otp;    // 1 = current sequence belongs to the OTP requester
    logic       r_last_otp;     // round-robin memory: 1 = OTP was granted last
    logic       r_otp_wr;
    logic [7:0] r_host_reg;
    logic [7:0] r_host_data;
    logic [2:0] r_idx;
    logic [2:0] r_retry;
    logic [7:0] r_gap_cnt;
    logic       r_err;
    logic       r_otp_gnt;
    logic       r_host_gnt;

    logic       w_take_otp;
    logic       w_take_host;
    logic       w_last_byte;
    logic [7:0] w_pass_byte;

    assign w_last_byte   = r_owner_otp ? (r_idx == LP_OTP_LAST) : 1'b1;
    assign bus.eng_dev   = DEV_ADDR;
    assign bus.otp_gnt   = r_otp_gnt;
    assign bus.host_gnt  = r_host_gnt;
    assign bus.otp_busy  = r_owner_otp && (r_state != S_IDLE);

    // Arbitration: a lone request wins; on a tie the requester not granted last wins.
    always_comb begin
        w_take_otp  = 1'b0;
        w_take_host = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.otp_req && bus.host_req) begin
                w_take_otp  = !r_last_otp;
                w_take_host = r_last_otp;
            end else begin
                w_take_otp  = bus.otp_req;
                w_take_host = bus.host_req;
            end
        end
    end

    // Passcode byte for the current index, most significant byte first.
    always_comb begin
        w_pass_byte = 8'h00;
        case (r_idx)
            3'd0:    w_pass_byte = PASSCODE[47:40];
            3'd1:    w_pass_byte = PASSCODE[39:32];
            3'd2:    w_pass_byte = PASSCODE[31:24];
            3'd3:    w_pass_byte = PASSCODE[23:16];
            3'd4:    w_pass_byte = PASSCODE[15:8];
            3'd5:    w_pass_byte = PASSCODE[7:0];
            default: w_pass_byte = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and engine/requester outputs.
    always_comb begin
        w_next        = r_state;
        bus.eng_valid = 1'b0;
        bus.eng_reg   = 8'h00;
        bus.eng_data  = 8'h00;
        bus.otp_done  = 1'b0;
        bus.otp_err   = 1'b0;
        bus.host_done = 1'b0;
        bus.host_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take_otp || w_take_host) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.eng_valid = 1'b1;
                if (!r_owner_otp) begin
                    bus.eng_reg  = r_host_reg;
                    bus.eng_data = r_host_data;
                end else if (r_idx == LP_OTP_LAST) begin
                    bus.eng_reg  = OTP_REG;
                    bus.eng_data = r_otp_wr ? 8'h11 : 8'h00;
                end else begin
                    bus.eng_reg  = PASS_REG;
                    bus.eng_data = w_pass_byte;
                end
                if (bus.eng_ready) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.eng_done) begin
                    if (!bus.eng_nack) w_next = w_last_byte ? S_FINISH : S_GAP;
                    else if (r_retry < LP_MAX_RETRY) w_next = S_GAP;
                    else w_next = S_FINISH;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) w_next = S_ISSUE;
            end
            S_FINISH: begin
                bus.otp_done  = r_owner_otp;
                bus.otp_err   = r_owner_otp && r_err;
                bus.host_done = !r_owner_otp;
                bus.host_err  = !r_owner_otp && r_err;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant pulses, operand capture, byte index/retry bookkeeping and gap timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_otp <= 1'b0;
            r_last_otp  <= 1'b0;
            r_otp_wr    <= 1'b0;
            r_host_reg  <= 8'h00;
            r_host_data <= 8'h00;
            r_idx       <= 3'd0;
            r_retry     <= 3'd0;
            r_gap_cnt   <= 8'd0;
            r_err       <= 1'b0;
            r_otp_gnt   <= 1'b0;
            r_host_gnt  <= 1'b0;
        end else begin
            r_otp_gnt  <= w_take_otp;
            r_host_gnt <= w_take_host;
            if (w_take_otp || w_take_host) begin
                r_owner_otp <= w_take_otp;
                r_last_otp  <= w_take_otp;
                r_idx       <= 3'd0;
                r_retry     <= 3'd0;
                r_err       <= 1'b0;
                if (w_take_otp) begin
                    r_otp_wr <= bus.otp_wr;
                end else begin
                    r_host_reg  <= bus.host_reg;
                    r_host_data <= bus.host_data;
                end
            end
            if (r_state == S_WAIT_DONE && bus.eng_done) begin
                if (!bus.eng_nack) begin
                    r_idx   <= r_idx + 3'd1;
                    r_retry <= 3'd0;
                end else if (r_retry < LP_MAX_RETRY) begin
                    r_retry <= r_retry + 3'd1;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_next == S_GAP && r_state != S_GAP) r_gap_cnt <= LP_GAP_LAST;
            else if (r_state == S_GAP && r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_otp_i2c_sequencer.sv
// tb_otp_i2c_sequencer: random requesters and a random engine against a transaction-level reference model.
// Each cycle the model predicts grants, done/err pulses, busy, eng_valid timing and command fields.
// Ends with a mid-sequence reset and a restart from the first passcode byte.
module tb_otp_i2c_sequencer;

    localparam int GAP       = 8;
    localparam int MAX_RETRY = 2;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    otp_i2c_sequencer_if bus ();

    otp_i2c_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] pass_bytes [0:5] = '{8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // stimulus knobs (percent)
    int k_ready_pct = 100;
    int k_nack_pct  = 0;
    int k_otp_pct   = 10;
    int k_host_pct  = 10;
    int k_keep_pct  = 50;
    int k_dly_min   = 1;
    int k_dly_max   = 4;
    bit k_stray     = 1'b1;

    // reference model
    cmd_t m_q[$];
    bit   m_active, m_owner_otp, m_last_otp, m_err, m_issue_pend, m_waiting, m_idle_prev;
    int   m_retry, m_issue_cyc, m_done_cyc, m_done_drv, m_idle_from, n_txn;
    bit   p_otp_req, p_host_req, p_otp_wr;
    logic [7:0] p_host_reg, p_host_data;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_owner_otp = 0; m_last_otp = 0; m_err = 0;
        m_issue_pend = 0; m_waiting = 0; m_idle_prev = 1;
        m_retry = 0; m_issue_cyc = 0; m_done_cyc = -1; m_done_drv = -1; m_idle_from = 0;
        p_otp_req = 0; p_host_req = 0; p_otp_wr = 0; p_host_reg = 0; p_host_data = 0;
    endtask

    task automatic tick();
        bit   eg_otp, eg_host, exp_done, exp_valid, win_otp, nk, idle_now;
        cmd_t c;
        @(posedge clk);
        #1;
        cyc++;
        eg_otp  = 0;
        eg_host = 0;
        // grant prediction from the requests present at the last edge
        if (m_idle_prev && (p_otp_req || p_host_req)) begin
            win_otp = p_otp_req && (!p_host_req || !m_last_otp);
            m_last_otp  = win_otp;
            m_owner_otp = win_otp;
            m_active    = 1;
            m_q.delete();
            if (win_otp) begin
                eg_otp = 1;
                for (int i = 0; i < 6; i++) begin
                    c.r = 8'h05; c.d = pass_bytes[i]; m_q.push_back(c);
                end
                c.r = 8'h04; c.d = p_otp_wr ? 8'h11 : 8'h00; m_q.push_back(c);
            end else begin
                eg_host = 1;
                c.r = p_host_reg; c.d = p_host_data; m_q.push_back(c);
            end
            m_retry = 0; m_err = 0; m_issue_pend = 1; m_issue_cyc = cyc;
        end
        check_eq("otp_gnt", bus.otp_gnt, eg_otp);
        check_eq("host_gnt", bus.host_gnt, eg_host);
        exp_done = (m_done_cyc == cyc);
        check_eq("otp_busy", bus.otp_busy, m_active && m_owner_otp);
        check_eq("otp_done", bus.otp_done, exp_done && m_owner_otp);
        check_eq("host_done", bus.host_done, exp_done && !m_owner_otp);
        if (exp_done) begin
            if (m_owner_otp) check_eq("otp_err", bus.otp_err, m_err);
            else             check_eq("host_err", bus.host_err, m_err);
            m_active = 0; m_idle_from = cyc + 1; m_done_cyc = -1; n_txn++;
        end
        exp_valid = m_issue_pend && (cyc >= m_issue_cyc);
        check_eq("eng_valid", bus.eng_valid, exp_valid);
        if (exp_valid && m_q.size() > 0) begin
            check_eq("eng_dev", bus.eng_dev, 7'h0A);
            check_eq("eng_reg", bus.eng_reg, m_q[0].r);
            check_eq("eng_data", bus.eng_data, m_q[0].d);
        end
        // engine responder
        bus.eng_ready = 0;
        bus.eng_done  = 0;
        bus.eng_nack  = 0;
        if (exp_valid && ($urandom_range(99) < k_ready_pct)) begin
            bus.eng_ready = 1;
            m_issue_pend = 0;
            m_waiting    = 1;
            m_done_drv   = cyc + int'($urandom_range(k_dly_max, k_dly_min));
        end else if (m_waiting && cyc == m_done_drv) begin
            nk = ($urandom_range(99) < k_nack_pct);
            bus.eng_done = 1;
            bus.eng_nack = nk;
            m_waiting = 0;
            if (!nk) begin
                void'(m_q.pop_front());
                m_retry = 0;
                if (m_q.size() == 0) m_done_cyc = cyc + 1;
                else begin m_issue_pend = 1; m_issue_cyc = cyc + 1 + GAP; end
            end else if (m_retry < MAX_RETRY) begin
                m_retry++;
                m_issue_pend = 1; m_issue_cyc = cyc + 1 + GAP;
            end else begin
                m_err = 1; m_q.delete(); m_done_cyc = cyc + 1;
            end
        end else if (!m_waiting && k_stray && $urandom_range(15) == 0) begin
            bus.eng_done = 1;
            bus.eng_nack = 1'($urandom_range(1));
        end
        // requesters: hold until granted, then drop or keep (a kept request is a new one)
        if (bus.otp_req) begin
            if (eg_otp) bus.otp_req = ($urandom_range(99) < k_keep_pct);
        end else bus.otp_req = ($urandom_range(99) < k_otp_pct);
        if (bus.host_req) begin
            if (eg_host) bus.host_req = ($urandom_range(99) < k_keep_pct);
        end else bus.host_req = ($urandom_range(99) < k_host_pct);
        bus.otp_wr    = 1'($urandom_range(1));
        bus.host_reg  = 8'($urandom_range(255));
        bus.host_data = 8'($urandom_range(255));
        p_otp_req   = bus.otp_req;
        p_host_req  = bus.host_req;
        p_otp_wr    = bus.otp_wr;
        p_host_reg  = bus.host_reg;
        p_host_data = bus.host_data;
        idle_now    = !m_active && (cyc >= m_idle_from);
        m_idle_prev = idle_now;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_eng_valid"}, bus.eng_valid, 0);
        check_eq({pfx, "_otp_gnt"},   bus.otp_gnt, 0);
        check_eq({pfx, "_host_gnt"},  bus.host_gnt, 0);
        check_eq({pfx, "_otp_done"},  bus.otp_done, 0);
        check_eq({pfx, "_host_done"}, bus.host_done, 0);
        check_eq({pfx, "_otp_err"},   bus.otp_err, 0);
        check_eq({pfx, "_host_err"},  bus.host_err, 0);
        check_eq({pfx, "_otp_busy"},  bus.otp_busy, 0);
        check_eq({pfx, "_eng_reg"},   bus.eng_reg, 0);
        check_eq({pfx, "_eng_data"},  bus.eng_data, 0);
        check_eq({pfx, "_eng_dev"},   bus.eng_dev, 7'h0A);
    endtask

    task automatic run_phase(input int rdy, input int nck, input int n);
        k_ready_pct = rdy;
        k_nack_pct  = nck;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int  start_txn;
        bit  found;
        bus.otp_req = 0; bus.otp_wr = 0; bus.host_req = 0; bus.host_reg = 0; bus.host_data = 0;
        bus.eng_ready = 0; bus.eng_done = 0; bus.eng_nack = 0;
        n_txn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;

        run_phase(100, 0, 2000);   // engine always ready, clean ACKs
        run_phase(40, 0, 2000);    // engine back-pressure
        run_phase(60, 35, 4000);   // NACK retries and aborts
        k_otp_pct = 25; k_host_pct = 25; k_keep_pct = 80;
        run_phase(100, 20, 2000);  // heavy contention

        // drain to idle with both requests low
        k_otp_pct = 0; k_host_pct = 0; k_keep_pct = 0; k_nack_pct = 0;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (m_idle_prev && !bus.otp_req && !bus.host_req) begin found = 1; break; end
        end
        check_eq("drain_timeout", found, 1);

        // reach WAIT_DONE of passcode byte index 4, then reset asynchronously
        k_otp_pct = 100; k_keep_pct = 100; k_ready_pct = 100;
        k_dly_min = 3; k_dly_max = 4; k_stray = 0;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (m_active && m_owner_otp && m_q.size() == 3 && m_waiting) begin found = 1; break; end
        end
        check_eq("rst_setup_timeout", found, 1);
        tick();
        check_eq("pre_rst_busy", bus.otp_busy, 1);
        #2;
        rst = 1;
        #1;
        check_reset_outputs("midrst");
        bus.otp_req = 0; bus.host_req = 0; bus.eng_ready = 0; bus.eng_nack = 0;
        @(negedge clk);
        bus.eng_done = 1;
        @(negedge clk);
        rst = 0;            // stray eng_done still high into the first edge after reset
        model_reset();
        k_keep_pct = 0;
        tick();
        tick();
        check_eq("restart_first_reg", bus.eng_reg, 8'h05);
        check_eq("restart_first_byte", bus.eng_data, 8'h50);
        start_txn = n_txn;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (n_txn > start_txn) begin found = 1; break; end
        end
        check_eq("restart_done_timeout", found, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/otp_i2c_sequencer.md
# otp_i2c_sequencer

Command sequencer and arbiter in front of the byte-level I2C write engine that talks to the OTP slave. Shares the engine between two requesters: an OTP command requester, which triggers the atomic unlock-and-command sequence (six passcode bytes to the passcode register, then one command byte to the OTP control register), and a host requester issuing single register writes. Handles engine back-pressure, NACK retry and inter-transaction bus-free gaps.

## Interface
- DEV_ADDR, 7'h0A, I2C device address placed on every engine command
- PASS_REG, 8'h05, passcode register address
- OTP_REG, 8'h04, OTP read/write control register address
- PASSCODE, 48'h50_48_53_47_4E_58, passcode bytes, sent MSB byte first ("PHSGNX")
- GAP_CYCLES, 8, idle cycles between consecutive engine commands (1..255)
- MAX_RETRY, 2, re-issues allowed per byte after NACK (0..7)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- otp_req  in  1  level request for the OTP sequence
- otp_wr  in  1  captured at grant: 1 = write OTP (cmd 8'h11), 0 = read OTP (cmd 8'h00)
- otp_gnt  out  1  one-cycle pulse, OTP request accepted
- otp_busy  out  1  high from grant through otp_done
- otp_done  out  1  one-cycle pulse, sequence finished
- otp_err  out  1  valid with otp_done; 1 = aborted on NACK
- host_req  in  1  level request for a single register write
- host_reg  in  8  register address, captured at grant
- host_data  in  8  data byte, captured at grant
- host_gnt  out  1  one-cycle pulse, host request accepted
- host_done  out  1  one-cycle pulse, write finished
- host_err  out  1  valid with host_done; 1 = NACK after all retries
- eng_valid  out  1  command valid to engine
- eng_ready  in  1  engine accepts command when eng_valid && eng_ready
- eng_dev  out  7  device address (= DEV_ADDR)
- eng_reg  out  8  register address
- eng_data  out  8  data byte
- eng_done  in  1  one-cycle pulse, engine transaction complete
- eng_nack  in  1  valid with eng_done; 1 = slave NACK

## Operation
- States: IDLE, ISSUE, WAIT_DONE, GAP, FINISH.
- IDLE: samples requests. If only one is high, that one is granted. If both are high, round-robin arbitration picks the requester not granted last; after reset OTP has priority. Grant pulse, operand capture, index=0 and retry=0 all occur on the transition to ISSUE.
- Requests are ignored outside IDLE. A requester still high in IDLE after its done pulse is treated as a new request.
- OTP sequence is atomic:
  - Index 0..5 sends PASSCODE byte[index] to PASS_REG.
  - Index 6 sends the command byte to OTP_REG.
  - Host sequence is one byte to host_reg.
- ISSUE: eng_valid=1 with eng_dev/reg/data stable until eng_ready. On the transfer, go to WAIT_DONE.
- WAIT_DONE: wait for eng_done.
  - eng_nack=0: index++ and retry=0. If that was the last byte, go to FINISH; else go to GAP.
  - eng_nack=1 and retry<MAX_RETRY: retry++, go to GAP, then re-issue the same byte.
  - eng_nack=1 and retry==MAX_RETRY: set err, go to FINISH. No further bytes are issued.
- GAP: counts GAP_CYCLES cycles with eng_valid=0, then go to ISSUE.
- FINISH: one cycle; pulses the done of the owning requester with its err; busy clears; go to IDLE.
- eng_done outside WAIT_DONE is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs 0 (eng_valid, grants, dones, errs, otp_busy, eng_reg, eng_data = 0); eng_dev=DEV_ADDR; round-robin pointer set so OTP wins the first tie.
- Reset mid-sequence abandons the sequence. No done pulse is generated.
- Request handshake:
  - Request high in IDLE at edge N: gnt=1 and eng_valid=1 in cycle N+1.
  - otp_busy rises in cycle N+1.
- Command transfer at edge T (valid&&ready): eng_valid=0 from cycle T+1.
- eng_done at edge D:
  - Next eng_valid rises in cycle D+1+GAP_CYCLES.
  - For the last byte, the done pulse appears in cycle D+1.
- Done-to-grant: the done pulse is in cycle F. IDLE is at F+1. The earliest next grant is at F+2.
- Minimum OTP sequence (eng_ready always 1, eng_done k cycles after transfer): 7 transfers, 6 gaps, plus grant and finish cycles.

## Test plan
- OTP write, ready=1, done 3 cycles after each transfer, no NACK → 7 commands: reg 0x05 with 0x50,0x48,0x53,0x47,0x4E,0x58, then reg 0x04 with 0x11. Each is separated by ≥8 idle cycles. otp_done=1 pulse, otp_err=0, eng_dev=0x0A throughout.
- host_req with reg 0x10, data 0xA5, eng_ready delayed 5 cycles → eng_valid held 6 cycles with stable fields. One transfer, then host_done pulse, host_err=0.
- otp_req and host_req both high after reset → OTP granted first (otp_wr=0, last byte 0x00). host_req raised mid-sequence is not granted until after otp_done. If both are high again after the host finishes, OTP wins; after OTP, host wins.
- NACK on passcode byte 2 once → byte 0x53 re-issued after the gap; sequence completes with otp_err=0.
- NACK on byte 2 three times (MAX_RETRY=2) → exactly 3 issues of 0x53, otp_done with otp_err=1, no write to reg 0x04.
- rst pulsed during WAIT_DONE of byte 4 → all outputs 0 immediately, state IDLE. A stray eng_done after reset is ignored. A new otp_req restarts from byte 0x50.
